// File: rtl/set_time_fsm.sv
// set_time_fsm: BCD time-setting controller with field select, range-aware increment, auto-repeat and inactivity abort.
// Define SET_TIME_SECONDS_EN to make the seconds digits editable fields 4 and 5.
module set_time_fsm #(
  parameter int HOUR_24     = 1,
  parameter int TIMEOUT_CYC = 1000,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_PER  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_time_en,
  input  logic       mode_button,
  input  logic       inc_button,
  input  logic [1:0] i_hours_left,
  input  logic [3:0] i_hours_right,
  input  logic [2:0] i_minutes_left,
  input  logic [3:0] i_minutes_right,
  input  logic [2:0] i_seconds_left,
  input  logic [3:0] i_seconds_right,
  output logic [1:0] o_hours_left,
  output logic [3:0] o_hours_right,
  output logic [2:0] o_minutes_left,
  output logic [3:0] o_minutes_right,
  output logic [2:0] o_seconds_left,
  output logic [3:0] o_seconds_right,
  output logic [2:0] o_field,
  output logic       ack_flag,
  output logic       abort_flag
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RMAX = REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [1:0] HL_MAX = HOUR_24 != 0 ? 2'd2 : 2'd1;
  logic [2:0] sl_in;
  logic [3:0] sr_in;
`ifdef SET_TIME_SECONDS_EN
  localparam logic [2:0] LAST = 3'd5;
  assign sl_in = i_seconds_left;
  assign sr_in = i_seconds_right;
`else
  localparam logic [2:0] LAST = 3'd3;
  logic unused_sec;
  assign sl_in = 3'd0;
  assign sr_in = 4'd0;
  assign unused_sec = ^{i_seconds_left, i_seconds_right};
`endif
  typedef enum logic [1:0] {IDLE, EDIT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] field_q, field_d;
  logic [1:0] hl_q, hl_d;
  logic [3:0] hr_q, hr_d;
  logic [2:0] ml_q, ml_d;
  logic [3:0] mr_q, mr_d;
  logic [2:0] sl_q, sl_d;
  logic [3:0] sr_q, sr_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic rep_on_q, rep_on_d;
  logic en_q, mode_q, inc_q, abort_q, abort_d;
  logic mode_e, inc_e, tick, bump, timeout;
  logic [1:0] hl_n;
  logic [3:0] hr_c, hr_max, hr_min, hr_n;
  always_comb begin
    mode_e = mode_button & ~mode_q;
    inc_e = inc_button & ~inc_q;
    tick = inc_button & ~inc_e & (rep_on_q ? rpt_q == RW'(REPEAT_PER - 1) : rpt_q == RW'(REPEAT_DLY - 1));
    bump = inc_e | tick;
    timeout = ~mode_e & ~inc_e & (idle_q == TW'(TIMEOUT_CYC - 2));
    hl_n = hl_q >= HL_MAX ? 2'd0 : hl_q + 2'd1;
    // hours-right is pulled back into range whenever hours-left changes
    hr_c = HOUR_24 != 0 ? ((hl_n == 2'd2 && hr_q > 4'd3) ? 4'd0 : hr_q)
         : (hl_n == 2'd1 && hr_q > 4'd2) ? 4'd0 : (hl_n == 2'd0 && hr_q == 4'd0) ? 4'd1 : hr_q;
    hr_max = HOUR_24 != 0 ? (hl_q == 2'd2 ? 4'd3 : 4'd9) : (hl_q == 2'd1 ? 4'd2 : 4'd9);
    hr_min = (HOUR_24 == 0 && hl_q != 2'd1) ? 4'd1 : 4'd0;
    hr_n = hr_q >= hr_max ? hr_min : hr_q + 4'd1;
    state_d = state_q;
    field_d = field_q;
    hl_d = hl_q;
    hr_d = hr_q;
    ml_d = ml_q;
    mr_d = mr_q;
    sl_d = sl_q;
    sr_d = sr_q;
    idle_d = idle_q;
    rpt_d = rpt_q;
    rep_on_d = rep_on_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: if (set_time_en && !en_q) begin
        state_d = EDIT;
        field_d = 3'd0;
        hl_d = i_hours_left;
        hr_d = i_hours_right;
        ml_d = i_minutes_left;
        mr_d = i_minutes_right;
        sl_d = sl_in;
        sr_d = sr_in;
        idle_d = '0;
        rpt_d = '0;
        rep_on_d = 1'b0;
      end
      EDIT: if (!set_time_en || timeout) begin
        abort_d = 1'b1;
        state_d = IDLE;
      end else begin
        idle_d = (mode_e | inc_e) ? '0 : idle_q + TW'(1);
        rpt_d = (mode_e | inc_e | tick | ~inc_button) ? '0 : rpt_q + RW'(1);
        rep_on_d = ~mode_e & ~inc_e & inc_button & (rep_on_q | tick);
        if (mode_e) begin
          state_d = field_q == LAST ? DONE : EDIT;
          field_d = field_q == LAST ? field_q : field_q + 3'd1;
        end else if (bump) begin
          hl_d = field_q == 3'd0 ? hl_n : hl_q;
          hr_d = field_q == 3'd0 ? hr_c : field_q == 3'd1 ? hr_n : hr_q;
          ml_d = field_q == 3'd2 ? (ml_q >= 3'd5 ? 3'd0 : ml_q + 3'd1) : ml_q;
          mr_d = field_q == 3'd3 ? (mr_q >= 4'd9 ? 4'd0 : mr_q + 4'd1) : mr_q;
          sl_d = field_q == 3'd4 ? (sl_q >= 3'd5 ? 3'd0 : sl_q + 3'd1) : sl_q;
          sr_d = field_q == 3'd5 ? (sr_q >= 4'd9 ? 4'd0 : sr_q + 4'd1) : sr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      field_q <= 3'd0;
      hl_q <= 2'd0;
      hr_q <= 4'd0;
      ml_q <= 3'd0;
      mr_q <= 4'd0;
      sl_q <= 3'd0;
      sr_q <= 4'd0;
      idle_q <= '0;
      rpt_q <= '0;
      rep_on_q <= 1'b0;
      en_q <= 1'b0;
      mode_q <= 1'b0;
      inc_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      hl_q <= hl_d;
      hr_q <= hr_d;
      ml_q <= ml_d;
      mr_q <= mr_d;
      sl_q <= sl_d;
      sr_q <= sr_d;
      idle_q <= idle_d;
      rpt_q <= rpt_d;
      rep_on_q <= rep_on_d;
      en_q <= set_time_en;
      mode_q <= mode_button;
      inc_q <= inc_button;
      abort_q <= abort_d;
    end
  end
  assign o_hours_left = hl_q;
  assign o_hours_right = hr_q;
  assign o_minutes_left = ml_q;
  assign o_minutes_right = mr_q;
  assign o_seconds_left = sl_q;
  assign o_seconds_right = sr_q;
  assign o_field = state_q == IDLE ? 3'd7 : field_q;
  assign ack_flag = state_q == DONE;
  assign abort_flag = abort_q;
endmodule

// File: tb/tb_set_time_fsm.sv
// tb_set_time_fsm: drives a 24 h and a 12 h instance with directed and random button activity against a cycle-level model.
module tb_set_time_fsm;
  localparam int T = 300, D = 50, P = 10;
`ifdef SET_TIME_SECONDS_EN
  localparam int LAST = 5;
`else
  localparam int LAST = 3;
`endif
  logic clk = 0, rst = 1, en = 0, mode = 0, inc = 0;
  logic [1:0] ihl = 0;
  logic [3:0] ihr = 0;
  logic [2:0] iml = 0;
  logic [3:0] imr = 0;
  logic [2:0] isl = 0;
  logic [3:0] isr = 0;
  logic [1:0] ohl [2];
  logic [3:0] ohr [2];
  logic [2:0] oml [2];
  logic [3:0] omr [2];
  logic [2:0] osl [2];
  logic [3:0] osr [2];
  logic [2:0] ofld [2];
  logic ack [2];
  logic abt [2];
  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
  int dg [2][6];
  int fld [2], st [2], last [2], anc [2];
  bit abt_e [2];
  bit en_p, mode_p, inc_p;

  always #5 clk = ~clk;

  set_time_fsm #(.HOUR_24(1), .TIMEOUT_CYC(T), .REPEAT_DLY(D), .REPEAT_PER(P)) u24 (
    .clk(clk), .rst(rst), .set_time_en(en), .mode_button(mode), .inc_button(inc),
    .i_hours_left(ihl), .i_hours_right(ihr), .i_minutes_left(iml), .i_minutes_right(imr),
    .i_seconds_left(isl), .i_seconds_right(isr),
    .o_hours_left(ohl[0]), .o_hours_right(ohr[0]), .o_minutes_left(oml[0]), .o_minutes_right(omr[0]),
    .o_seconds_left(osl[0]), .o_seconds_right(osr[0]), .o_field(ofld[0]), .ack_flag(ack[0]), .abort_flag(abt[0]));

  set_time_fsm #(.HOUR_24(0), .TIMEOUT_CYC(T), .REPEAT_DLY(D), .REPEAT_PER(P)) u12 (
    .clk(clk), .rst(rst), .set_time_en(en), .mode_button(mode), .inc_button(inc),
    .i_hours_left(ihl), .i_hours_right(ihr), .i_minutes_left(iml), .i_minutes_right(imr),
    .i_seconds_left(isl), .i_seconds_right(isr),
    .o_hours_left(ohl[1]), .o_hours_right(ohr[1]), .o_minutes_left(oml[1]), .o_minutes_right(omr[1]),
    .o_seconds_left(osl[1]), .o_seconds_right(osr[1]), .o_field(ofld[1]), .ack_flag(ack[1]), .abort_flag(abt[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 6; j++) dg[k][j] = 0;
      fld[k] = 0; st[k] = 0; last[k] = 0; anc[k] = 0; abt_e[k] = 0;
    end
    en_p = 0; mode_p = 0; inc_p = 0;
  endtask

  // increment the selected field of format k using the legal digit ranges
  task automatic bump(input int k);
    bit h24;
    int hi, lo;
    h24 = (k == 0);
    case (fld[k])
      0: begin
        dg[k][0] = dg[k][0] >= (h24 ? 2 : 1) ? 0 : dg[k][0] + 1;
        if (h24) begin
          if (dg[k][0] == 2 && dg[k][1] > 3) dg[k][1] = 0;
        end else if (dg[k][0] == 1 && dg[k][1] > 2) dg[k][1] = 0;
        else if (dg[k][0] == 0 && dg[k][1] == 0) dg[k][1] = 1;
      end
      1: begin
        hi = h24 ? (dg[k][0] == 2 ? 3 : 9) : (dg[k][0] == 1 ? 2 : 9);
        lo = (!h24 && dg[k][0] != 1) ? 1 : 0;
        dg[k][1] = dg[k][1] >= hi ? lo : dg[k][1] + 1;
      end
      2, 4: dg[k][fld[k]] = dg[k][fld[k]] >= 5 ? 0 : dg[k][fld[k]] + 1;
      default: dg[k][fld[k]] = dg[k][fld[k]] >= 9 ? 0 : dg[k][fld[k]] + 1;
    endcase
  endtask

  // advance the model by the clock edge about to happen, using the inputs now applied
  task automatic mstep();
    bit me, ie;
    me = mode && !mode_p;
    ie = inc && !inc_p;
    for (int k = 0; k < 2; k++) begin
      abt_e[k] = 0;
      if (st[k] == 0) begin
        if (en && !en_p) begin
          dg[k][0] = int'(ihl); dg[k][1] = int'(ihr); dg[k][2] = int'(iml); dg[k][3] = int'(imr);
`ifdef SET_TIME_SECONDS_EN
          dg[k][4] = int'(isl); dg[k][5] = int'(isr);
`else
          dg[k][4] = 0; dg[k][5] = 0;
`endif
          fld[k] = 0; last[k] = cyc; anc[k] = cyc; st[k] = 1;
        end
      end else if (st[k] == 2) st[k] = 0;
      else if (!en) begin
        abt_e[k] = 1; st[k] = 0;
      end else if (!(me || ie) && cyc - last[k] == T - 1) begin
        abt_e[k] = 1; st[k] = 0;
      end else begin
        if (me || ie) last[k] = cyc;
        if (me) begin
          anc[k] = cyc;
          if (fld[k] == LAST) st[k] = 2;
          else fld[k]++;
        end else if (ie) begin
          anc[k] = cyc;
          bump(k);
        end else if (inc && cyc - anc[k] >= D && (cyc - anc[k] - D) % P == 0) bump(k);
      end
    end
    en_p = en; mode_p = mode; inc_p = inc;
    cyc++;
  endtask

  task automatic check_all();
    logic [19:0] e;
    for (int k = 0; k < 2; k++) begin
      e = {2'(dg[k][0]), 4'(dg[k][1]), 3'(dg[k][2]), 4'(dg[k][3]), 3'(dg[k][4]), 4'(dg[k][5])};
      chk($sformatf("digits%0d@%0d", k, cyc), {ohl[k], ohr[k], oml[k], omr[k], osl[k], osr[k]}, e);
      chk($sformatf("field%0d@%0d", k, cyc), ofld[k], st[k] == 0 ? 7 : fld[k]);
      chk($sformatf("ack%0d@%0d", k, cyc), ack[k], st[k] == 2);
      chk($sformatf("abort%0d@%0d", k, cyc), abt[k], abt_e[k]);
    end
  endtask

  task automatic cyc1();
    mstep();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic press_inc();
    inc = 1; cyc1(); inc = 0; cyc1();
  endtask

  task automatic press_mode();
    mode = 1; cyc1(); mode = 0; cyc1();
  endtask

  task automatic enter(input int hl, input int hr, input int ml, input int mr);
    en = 0; cyc1();
    ihl = 2'(hl); ihr = 4'(hr); iml = 3'(ml); imr = 4'(mr); isl = 3'd0; isr = 4'd0;
    en = 1; cyc1();
  endtask

  task automatic chk_hm(input string tag, input int k, input int hl, input int hr, input int ml, input int mr);
    chk(tag, {ohl[k], ohr[k], oml[k], omr[k]}, {2'(hl), 4'(hr), 3'(ml), 4'(mr)});
  endtask

  initial begin
    int n, hold, quiet;
    bit seen, ack_seen;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_field", ofld[0], 7);
    rst = 0;
    cyc1();
    // 24 h: 19:59, HL inc clamps HR, then HR wraps at 3
    enter(1, 9, 5, 9);
    press_inc();
    chk_hm("hl_clamp24", 0, 2, 0, 5, 9);
    press_mode();
    press_inc(); chk_hm("hr24_1", 0, 2, 1, 5, 9);
    press_inc(); chk_hm("hr24_2", 0, 2, 2, 5, 9);
    press_inc(); chk_hm("hr24_3", 0, 2, 3, 5, 9);
    press_inc(); chk_hm("hr24_wrap", 0, 2, 0, 5, 9);
    en = 0; cyc1();
    chk("abort_en_low", abt[0], 1);
    // 12 h: 09:00 -> 10:00 -> 01:00
    enter(0, 9, 0, 0);
    press_inc(); chk_hm("hl12_a", 1, 1, 0, 0, 0);
    press_inc(); chk_hm("hl12_b", 1, 0, 1, 0, 0);
    // full commit from 00:00
    enter(0, 0, 0, 0);
    for (int f = 0; f <= LAST; f++) begin
      press_inc(); press_inc();
      if (f < LAST) press_mode();
    end
    mode = 1; cyc1();
    chk("commit_ack", ack[0], 1);
    chk_hm("commit_time", 0, 2, 2, 2, 2);
`ifdef SET_TIME_SECONDS_EN
    chk("commit_sec", {osl[0], osr[0]}, {3'd2, 4'd2});
`endif
    mode = 0; cyc1();
    chk("ack_one_cycle", ack[0], 0);
    chk("field_idle", ofld[0], 7);
    cyc1();
    // timeout with no buttons
    en = 0; cyc1();
    en = 1; cyc1();
    n = 1; seen = 0; ack_seen = 0;
    while (n < 2 * T && !seen) begin
      if (abt[0]) seen = 1;
      else begin
        cyc1(); n++;
        ack_seen |= ack[0];
      end
    end
    chk("timeout_cycles", n, T);
    chk("timeout_no_ack", ack_seen, 0);
    repeat (3) cyc1();
    // auto-repeat on MR
    enter(0, 0, 0, 0);
    repeat (3) press_mode();
    inc = 1;
    repeat (81) cyc1();
    inc = 0; cyc1();
    chk_hm("repeat24", 0, 0, 0, 0, 5);
    chk_hm("repeat12", 1, 0, 0, 0, 5);
    // simultaneous edges at ML = 3, then mid-edit reset
    enter(0, 0, 3, 0);
    repeat (2) press_mode();
    mode = 1; inc = 1; cyc1();
    mode = 0; inc = 0;
    chk("simul_field", ofld[0], 3);
    chk_hm("simul_ml", 0, 0, 0, 3, 0);
    cyc1();
    #2 rst = 1; en = 0;
    #1 mreset();
    check_all();
    chk("rst_async_field", ofld[0], 7);
    chk("rst_async_digits", {ohl[0], ohr[0], oml[0], omr[0]}, 0);
    @(posedge clk); #1;
    rst = 0;
    cyc1();
    // random phase
    hold = 0; quiet = 0;
    for (int i = 0; i < 2500; i++) begin
      if (!en && $urandom_range(0, 3) == 0) en = 1;
      else if ($urandom_range(0, 200) == 0) en = 0;
      if (quiet == 0 && $urandom_range(0, 700) == 0) quiet = T + 5;
      if (quiet > 0) begin
        mode = 0; inc = 0; quiet--;
      end else begin
        mode = ($urandom_range(0, 11) == 0);
        if (hold > 0) begin
          inc = 1; hold--;
        end else begin
          inc = ($urandom_range(0, 5) == 0);
          if ($urandom_range(0, 60) == 0) hold = $urandom_range(20, 120);
        end
      end
      ihl = 2'($urandom_range(0, 2)); ihr = 4'($urandom_range(0, 9));
      iml = 3'($urandom_range(0, 5)); imr = 4'($urandom_range(0, 9));
      isl = 3'($urandom_range(0, 5)); isr = 4'($urandom_range(0, 9));
      cyc1();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
